bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 3-digit BCD converter (shift-and-add-3).
// Define BIN2BCD_SEG7_OUT_EN to add active-low 7-segment digit outputs.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
`ifdef BIN2BCD_SEG7_OUT_EN
    ,
    output logic [6:0] seg_hund,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [6:0]  sh, sh_n;
    logic [11:0] scr, scr_n, adj;
    logic [18:0] shv;
    logic [3:0]  hund_n, tens_n, ones_n;
    logic        done_n;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign adj  = {add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0])};
    assign shv  = {adj, sh} << 1;
    assign busy = (state == SHIFT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        scr_n   = scr;
        hund_n  = bcd_hund;
        tens_n  = bcd_tens;
        ones_n  = bcd_ones;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sh_n    = bin;
                    scr_n   = '0;
                    cnt_n   = 3'd7;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                scr_n = shv[18:7];
                sh_n  = shv[6:0];
                cnt_n = cnt - 3'd1;
                // cnt==1 means this edge performs the seventh shift
                if (cnt == 3'd1) begin
                    hund_n  = scr_n[11:8];
                    tens_n  = scr_n[7:4];
                    ones_n  = scr_n[3:0];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            scr      <= '0;
            bcd_hund <= '0;
            bcd_tens <= '0;
            bcd_ones <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            scr      <= scr_n;
            bcd_hund <= hund_n;
            bcd_tens <= tens_n;
            bcd_ones <= ones_n;
            done     <= done_n;
        end
    end

`ifdef BIN2BCD_SEG7_OUT_EN
    // Bit order {g,f,e,d,c,b,a}, active-low; non-decimal codes blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b1111111;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign seg_hund = seg7(bcd_hund);
    assign seg_tens = seg7(bcd_tens);
    assign seg_ones = seg7(bcd_ones);
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model plus
// directed vectors with literal expectations.
module tb_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] bin;
    logic       busy, done;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;
`ifdef BIN2BCD_SEG7_OUT_EN
    logic [6:0] seg_hund, seg_tens, seg_ones;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
`ifdef BIN2BCD_SEG7_OUT_EN
        ,
        .seg_hund (seg_hund),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a conversion occupies 7 cycles after acceptance,
    // then the decimal digits of the captured value appear with done.
    int       m_left = 0;
    int       m_val  = 0;
    logic     m_done = 1'b0;
    int       m_h = 0, m_t = 0, m_o = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_h = 0; m_t = 0; m_o = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_h = m_val / 100;
                    m_t = (m_val / 10) % 10;
                    m_o = m_val % 10;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_val  = int'(bin);
                m_left = 7;
            end
        end
    end

    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000};
        return (d >= 0 && d <= 9) ? tbl[d] : 7'b1111111;
    endfunction

    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_left > 0);
        n_checks++;
        if (busy !== m_busy || done !== m_done ||
            int'(bcd_hund) != m_h || int'(bcd_tens) != m_t ||
            int'(bcd_ones) != m_o) begin
            n_fail++;
            $display("FAIL model t=%0t: busy/done/h/t/o got %b %b %0d %0d %0d want %b %b %0d %0d %0d",
                     $time, busy, done, bcd_hund, bcd_tens, bcd_ones,
                     m_busy, m_done, m_h, m_t, m_o);
        end
`ifdef BIN2BCD_SEG7_OUT_EN
        n_checks++;
        if (seg_hund !== seg_ref(m_h) || seg_tens !== seg_ref(m_t) ||
            seg_ones !== seg_ref(m_o)) begin
            n_fail++;
            $display("FAIL seg_model t=%0t: got %b %b %b want %b %b %b",
                     $time, seg_hund, seg_tens, seg_ones,
                     seg_ref(m_h), seg_ref(m_t), seg_ref(m_o));
        end
`endif
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_dig(input string name, input int h, input int t, input int o);
        chk({name, "_hund"}, int'(bcd_hund), h);
        chk({name, "_tens"}, int'(bcd_tens), t);
        chk({name, "_ones"}, int'(bcd_ones), o);
    endtask

    // Pulse start for one cycle, then scramble bin; returns busy cycle
    // count and the negedge index (1 = first after accept) showing done.
    task automatic conv(input logic [6:0] b, output int bcyc, output int dcyc);
        bit found;
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        @(negedge clk);
        start = 1'b0;
        bin   = ~b;
        bcyc  = 0;
        dcyc  = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            if (busy) bcyc++;
            if (done) begin
                dcyc  = i;
                found = 1'b1;
            end
            if (!found) @(negedge clk);
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL conv_timeout: got no done want done for bin=%0d", b);
        end
    endtask

    initial begin
        int bc, dc, ndone, last, gap_bad;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk_dig("reset", 0, 0, 0);
        rst = 1'b0;

        conv(7'd98, bc, dc);
        chk("b98_busy_cycles", bc, 7);
        chk("b98_done_index", dc, 8);
        chk_dig("b98", 0, 9, 8);
`ifdef BIN2BCD_SEG7_OUT_EN
        chk("b98_seg_hund", int'(seg_hund), int'(7'b1000000));
        chk("b98_seg_tens", int'(seg_tens), int'(7'b0010000));
        chk("b98_seg_ones", int'(seg_ones), int'(7'b0000000));
`endif
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk_dig("b98_hold", 0, 9, 8);

        conv(7'd0, bc, dc);
        chk_dig("b0", 0, 0, 0);
        conv(7'd127, bc, dc);
        chk_dig("b127", 1, 2, 7);

        for (int v = 0; v < 128; v++) begin
            conv(7'(v), bc, dc);
            n_checks++;
            if (100 * int'(bcd_hund) + 10 * int'(bcd_tens) + int'(bcd_ones) != v ||
                bcd_tens > 4'd9 || bcd_ones > 4'd9) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", v,
                         bcd_hund, bcd_tens, bcd_ones, v / 100, (v / 10) % 10, v % 10);
            end
        end

        // Second request two cycles into a conversion must be ignored
        @(negedge clk);
        start = 1'b1; bin = 7'd55;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; bin = 7'd13;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (done) ndone++;
        end
        chk("b55_done_count", ndone, 1);
        chk_dig("b55", 0, 5, 5);

        // Reset mid-conversion aborts immediately
        @(negedge clk);
        start = 1'b1; bin = 7'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst77_busy", int'(busy), 0);
        chk("rst77_done", int'(done), 0);
        chk_dig("rst77", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst77_no_done", ndone, 0);

        conv(7'd9, bc, dc);
        chk("post_rst_done_index", dc, 8);
        chk_dig("b9", 0, 0, 9);

        // Continuous start: one result every 8 cycles
        @(negedge clk);
        start = 1'b1; bin = 7'd49;
        ndone = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0 && i - last != 8) gap_bad++;
                last = i;
                ndone++;
            end
            if (ndone > 0 && (bcd_hund != 4'd0 || bcd_tens != 4'd4 || bcd_ones != 4'd9))
                gap_bad++;
        end
        start = 1'b0;
        chk("b49_done_count", ndone, 5);
        chk("b49_gap_or_hold_errors", gap_bad, 0);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
